// File: rtl/spi3w_xcvr_param.sv
// Half-duplex 3-wire SPI transceiver: master write/read frames, slave receive with idle realignment.
// Optional build macro SPI3W_PARITY_EN appends an even-parity bit to every frame and adds rx_parity_err.
module spi3w_xcvr_param #(
    parameter int DATA_W      = 8,
    parameter int CLK_DIV     = 4,
    parameter bit CPOL        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_master,
    input  logic              start,
    input  logic              rd_nwr,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
`ifdef SPI3W_PARITY_EN
    output logic              rx_parity_err,
`endif
    inout  wire               spi_sclk,
    inout  wire               spi_sdio
);

`ifdef SPI3W_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int BCNT_W = $clog2(FRAME_BITS + 1);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sh, input logic b);
        if (LSB_FIRST) return {b, sh[DATA_W-1:1]};
        else           return {sh[DATA_W-2:0], b};
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] sh);
        if (LSB_FIRST) return sh >> 1;
        else           return sh << 1;
    endfunction

    state_t             state, state_nx;
    logic               accept, toggle, trail, finish, div_end;
    logic [DIV_W-1:0]   div_cnt;
    logic [BCNT_W-1:0]  bit_cnt, s_bit_cnt, s_eff_cnt, rx_idx;
    logic [TO_W-1:0]    to_cnt;
    logic               sclk_o, sclk_oe, sdio_o, sdio_oe, rd_frame;
    logic [DATA_W-1:0]  tx_sh, rx_sh, word_data;
    logic               sclk_p0, sclk_p1, sclk_p2, sdio_p0, sdio_p1;
    logic               s_lead, to_sat, rx_en, word_done;
`ifdef SPI3W_PARITY_EN
    logic               tx_par, rx_par, word_perr;
`endif

    assign spi_sclk = sclk_oe ? sclk_o : 1'bz;
    assign spi_sdio = sdio_oe ? sdio_o : 1'bz;
    assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));

`ifdef SPI3W_PARITY_EN
    assign sdio_o = (bit_cnt == BCNT_W'(DATA_W)) ? tx_par
                  : (LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1]);
`else
    assign sdio_o = LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        toggle   = 1'b0;
        trail    = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = XFER;
            end
            XFER: if (div_end) begin
                toggle = 1'b1;
                trail  = (sclk_o != CPOL);
                if (trail && bit_cnt == LAST_BIT) state_nx = HOLD;
            end
            HOLD: if (div_end) begin
                finish   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (!is_master) begin
            state_nx = IDLE;
            accept   = 1'b0;
            toggle   = 1'b0;
            trail    = 1'b0;
            finish   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk_oe  <= 1'b0;
            sdio_oe  <= 1'b0;
            sclk_o   <= CPOL;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            rd_frame <= 1'b0;
        end else begin
            sclk_oe <= is_master;
            done    <= finish;
            if (accept) begin
                busy     <= 1'b1;
                sdio_oe  <= !rd_nwr;
                rd_frame <= rd_nwr;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                sclk_o   <= CPOL;
            end else if (!is_master || finish) begin
                busy    <= 1'b0;
                sdio_oe <= 1'b0;
                sclk_o  <= CPOL;
                div_cnt <= '0;
            end else if (state != IDLE) begin
                div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
                if (toggle) sclk_o <= ~sclk_o;
                if (trail && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + BCNT_W'(1);
            end
        end
    end

    // input synchronisers: 3 stages for SCLK (edge detect), 2 for SDIO
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_p0 <= CPOL;
            sclk_p1 <= CPOL;
            sclk_p2 <= CPOL;
        end else begin
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
        end
        sdio_p0 <= spi_sdio;
        sdio_p1 <= sdio_p0;
    end

    assign s_lead    = !is_master && (sclk_p1 != CPOL) && (sclk_p2 == CPOL);
    assign to_sat    = (to_cnt == TO_W'(TIMEOUT_CYC));
    assign s_eff_cnt = to_sat ? '0 : s_bit_cnt;
    assign rx_en     = (trail && rd_frame) || s_lead;
    assign rx_idx    = s_lead ? s_eff_cnt : bit_cnt;

    always_ff @(posedge clk) begin
        if (rst || is_master) begin
            s_bit_cnt <= '0;
            to_cnt    <= '0;
        end else if (s_lead) begin
            to_cnt    <= '0;
            s_bit_cnt <= (s_eff_cnt == LAST_BIT) ? '0 : s_eff_cnt + BCNT_W'(1);
        end else if (to_sat) begin
            s_bit_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_sh <= tx_data;
`ifdef SPI3W_PARITY_EN
            tx_par <= ^tx_data;
`endif
        end else if (trail && bit_cnt != LAST_BIT) begin
            tx_sh <= shift_out(tx_sh);
        end
        if (rx_en) begin
            if (rx_idx < BCNT_W'(DATA_W)) rx_sh <= shift_in(rx_sh, sdio_p1);
`ifdef SPI3W_PARITY_EN
            else rx_par <= sdio_p1;
`endif
        end
    end

    // a master read completes at done; a slave word completes on its final leading edge
    always_comb begin
        word_done = 1'b0;
        word_data = rx_sh;
`ifdef SPI3W_PARITY_EN
        word_perr = 1'b0;
`endif
        if (finish && rd_frame) begin
            word_done = 1'b1;
`ifdef SPI3W_PARITY_EN
            word_perr = (^rx_sh) ^ rx_par;
`endif
        end else if (s_lead && s_eff_cnt == LAST_BIT) begin
            word_done = 1'b1;
`ifdef SPI3W_PARITY_EN
            word_perr = (^rx_sh) ^ sdio_p1;
`else
            word_data = shift_in(rx_sh, sdio_p1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef SPI3W_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else if (word_done) begin
            rx_data    <= word_data;
            rx_valid   <= 1'b1;
            rx_overrun <= !rx_ack && (rx_overrun || rx_valid);
`ifdef SPI3W_PARITY_EN
            rx_parity_err <= word_perr;
`endif
        end else if (rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
`ifdef SPI3W_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_spi3w_xcvr_param.sv
// Directed bench for spi3w_xcvr_param: 8-bit CPOL0/MSB instance on bus A, 12-bit CPOL1/LSB master+slave pair on bus B.
module tb_spi3w_xcvr_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_is_master = 1'b1, a_start = 1'b0, a_rd_nwr = 1'b0, a_rx_ack = 1'b0;
    logic [7:0]  a_tx_data = '0;
    logic        a_busy, a_done, a_rx_valid, a_rx_overrun;
    logic [7:0]  a_rx_data;
    logic        tb_sclk_oe = 1'b0, tb_sclk = 1'b0, tb_sdio_oe = 1'b0, tb_sdio = 1'b0;
    wire         sclk_a, sdio_a;
    assign sclk_a = tb_sclk_oe ? tb_sclk : 1'bz;
    assign sdio_a = tb_sdio_oe ? tb_sdio : 1'bz;

    logic        b_start = 1'b0;
    logic [11:0] b_tx_data = '0;
    logic        mb_busy, mb_done, mb_rx_valid, mb_rx_overrun;
    logic [11:0] mb_rx_data;
    logic        sb_busy, sb_done, sb_rx_valid, sb_rx_overrun;
    logic [11:0] sb_rx_data;
    wire         sclk_b, sdio_b;
`ifdef SPI3W_PARITY_EN
    logic        a_perr, mb_perr, sb_perr;
`endif

    spi3w_xcvr_param #(.DATA_W(8), .CLK_DIV(4), .CPOL(1'b0), .LSB_FIRST(1'b0), .TIMEOUT_CYC(32)) u_a (
        .clk(clk), .rst(rst), .is_master(a_is_master), .start(a_start), .rd_nwr(a_rd_nwr),
        .tx_data(a_tx_data), .busy(a_busy), .done(a_done), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ack(a_rx_ack), .rx_overrun(a_rx_overrun),
`ifdef SPI3W_PARITY_EN
        .rx_parity_err(a_perr),
`endif
        .spi_sclk(sclk_a), .spi_sdio(sdio_a));

    spi3w_xcvr_param #(.DATA_W(12), .CLK_DIV(4), .CPOL(1'b1), .LSB_FIRST(1'b1), .TIMEOUT_CYC(32)) u_mb (
        .clk(clk), .rst(rst), .is_master(1'b1), .start(b_start), .rd_nwr(1'b0),
        .tx_data(b_tx_data), .busy(mb_busy), .done(mb_done), .rx_data(mb_rx_data),
        .rx_valid(mb_rx_valid), .rx_ack(1'b0), .rx_overrun(mb_rx_overrun),
`ifdef SPI3W_PARITY_EN
        .rx_parity_err(mb_perr),
`endif
        .spi_sclk(sclk_b), .spi_sdio(sdio_b));

    spi3w_xcvr_param #(.DATA_W(12), .CLK_DIV(4), .CPOL(1'b1), .LSB_FIRST(1'b1), .TIMEOUT_CYC(32)) u_sb (
        .clk(clk), .rst(rst), .is_master(1'b0), .start(1'b0), .rd_nwr(1'b0),
        .tx_data(12'h000), .busy(sb_busy), .done(sb_done), .rx_data(sb_rx_data),
        .rx_valid(sb_rx_valid), .rx_ack(1'b0), .rx_overrun(sb_rx_overrun),
`ifdef SPI3W_PARITY_EN
        .rx_parity_err(sb_perr),
`endif
        .spi_sclk(sclk_b), .spi_sdio(sdio_b));

    int   n_cmp = 0;
    int   n_err = 0;
    int   a_vld_rises = 0;
    logic a_vld_prev = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (a_rx_valid && !a_vld_prev) a_vld_rises++;
        a_vld_prev = a_rx_valid;
    endtask

    // Master frame on bus A; for reads the bench plays the remote, changing SDIO on each falling SCLK.
    task automatic a_frame(input logic [7:0] d, input logic rd, input logic [7:0] rd_word,
                           output int done_cyc, output logic [7:0] cap, output int n_rise,
                           output int n_done, output logic oe_seen);
        logic prev_sclk;
        int   idx;
        done_cyc = -1; cap = '0; n_rise = 0; n_done = 0; oe_seen = 1'b0; idx = 7;
        a_tx_data = d; a_rd_nwr = rd; a_start = 1'b1;
        if (rd) begin
            tb_sdio_oe = 1'b1;
            tb_sdio    = rd_word[7];
        end
        prev_sclk = sclk_a;
        tick();
        a_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 1) begin
                chk_eq("busy_after_accept", {31'b0, a_busy}, 32'd1);
                if (!rd) chk_eq("first_bit", {31'b0, sdio_a}, {31'b0, d[7]});
            end
            if (sclk_a && !prev_sclk) begin
                n_rise++;
                cap = {cap[6:0], sdio_a};
            end
            if (!sclk_a && prev_sclk && rd && idx > 0) begin
                idx--;
                tb_sdio = rd_word[idx];
            end
            if (rd && u_a.sdio_oe) oe_seen = 1'b1;
            if (a_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                if (rd) begin
                    chk_eq("rd_rx_data_at_done", {24'b0, a_rx_data}, {24'b0, rd_word});
                    chk_eq("rd_rx_valid_at_done", {31'b0, a_rx_valid}, 32'd1);
                end
            end
            prev_sclk = sclk_a;
            if (c == 30 && !rd) begin
                a_start   = 1'b1;
                a_tx_data = ~d;
            end
            if (c == 31) a_start = 1'b0;
            tick();
        end
        chk_eq("busy_low_after_frame", {31'b0, a_busy}, 32'd0);
        tb_sdio_oe = 1'b0;
    endtask

    task automatic s_bit(input logic b);
        tb_sdio = b;
        repeat (4) tick();
        tb_sclk = 1'b1;
        repeat (4) tick();
        tb_sclk = 1'b0;
    endtask

    task automatic s_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) s_bit(w[i]);
    endtask

    task automatic a_pop();
        a_rx_ack = 1'b1;
        tick();
        a_rx_ack = 1'b0;
    endtask

    initial begin
        int         dc, nr, nd, bdone;
        logic [7:0] cap;
        logic       oe;

        repeat (3) tick();
        chk_eq("rst_busy", {31'b0, a_busy}, 32'd0);
        chk_eq("rst_done", {31'b0, a_done}, 32'd0);
        chk_eq("rst_rx_valid", {31'b0, a_rx_valid}, 32'd0);
        chk_eq("rst_rx_overrun", {31'b0, a_rx_overrun}, 32'd0);
        chk_eq("rst_rx_data", {24'b0, a_rx_data}, 32'd0);
        chk_eq("rst_sclk_oe", {31'b0, u_a.sclk_oe}, 32'd0);
        chk_eq("rst_sdio_oe", {31'b0, u_a.sdio_oe}, 32'd0);
        chk_eq("rst_sclk_o_cpol1", {31'b0, u_mb.sclk_o}, 32'd1);
        rst = 1'b0;
        repeat (2) tick();
        chk_eq("idle_sclk_a", {31'b0, sclk_a}, 32'd0);

        a_frame(8'hA5, 1'b0, 8'h00, dc, cap, nr, nd, oe);
        chk_eq("wr_done_cycle", dc, 32'd69);
        chk_eq("wr_bits_on_rise", {24'b0, cap}, 32'h0000_00A5);
        chk_eq("wr_rise_count", nr, 32'd8);
        chk_eq("wr_done_count", nd, 32'd1);

        a_frame(8'h00, 1'b1, 8'h3C, dc, cap, nr, nd, oe);
        chk_eq("rd_done_cycle", dc, 32'd69);
        chk_eq("rd_sdio_oe_seen", {31'b0, oe}, 32'd0);
        a_pop();
        chk_eq("rd_ack_clears_valid", {31'b0, a_rx_valid}, 32'd0);

        // abort after three bits by dropping master mode
        a_tx_data = 8'hFF; a_rd_nwr = 1'b0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (24) tick();
        a_is_master = 1'b0;
        tick();
        chk_eq("abort_sclk_oe", {31'b0, u_a.sclk_oe}, 32'd0);
        chk_eq("abort_sdio_oe", {31'b0, u_a.sdio_oe}, 32'd0);
        chk_eq("abort_busy", {31'b0, a_busy}, 32'd0);
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_done) nd++;
            tick();
        end
        chk_eq("abort_no_done", nd, 32'd0);
        a_is_master = 1'b1;
        repeat (3) tick();
        a_frame(8'h5A, 1'b0, 8'h00, dc, cap, nr, nd, oe);
        chk_eq("post_abort_done_cycle", dc, 32'd69);
        chk_eq("post_abort_bits", {24'b0, cap}, 32'h0000_005A);

        // slave receive on bus A
        a_is_master = 1'b0;
        tb_sclk = 1'b0; tb_sclk_oe = 1'b1; tb_sdio_oe = 1'b1; tb_sdio = 1'b0;
        repeat (40) tick();
        a_vld_rises = 0;
        s_bit(1'b1); s_bit(1'b0); s_bit(1'b1);
        repeat (40) tick();
        s_word(8'h81);
        repeat (6) tick();
        chk_eq("slv_timeout_rx_data", {24'b0, a_rx_data}, 32'h0000_0081);
        chk_eq("slv_timeout_rises", a_vld_rises, 32'd1);
        chk_eq("slv_timeout_valid", {31'b0, a_rx_valid}, 32'd1);
        a_pop();

        s_word(8'h11);
        s_word(8'h22);
        repeat (6) tick();
        chk_eq("slv_ovr_rx_data", {24'b0, a_rx_data}, 32'h0000_0022);
        chk_eq("slv_ovr_flag", {31'b0, a_rx_overrun}, 32'd1);
        chk_eq("slv_ovr_valid", {31'b0, a_rx_valid}, 32'd1);
        a_pop();
        chk_eq("slv_ack_valid", {31'b0, a_rx_valid}, 32'd0);
        chk_eq("slv_ack_overrun", {31'b0, a_rx_overrun}, 32'd0);

        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk_eq("start_in_slave_ignored", {31'b0, a_busy}, 32'd0);

        // bus B: CPOL=1, LSB first, 12-bit master to slave
        chk_eq("b_sclk_idle_high", {31'b0, sclk_b}, 32'd1);
        b_tx_data = 12'h5A3; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk_eq("b_first_bit_lsb", {31'b0, sdio_b}, 32'd1);
        chk_eq("b_sdio_oe", {31'b0, u_mb.sdio_oe}, 32'd1);
        bdone = -1;
        for (int c = 1; c <= 130; c++) begin
            if (mb_done && bdone < 0) bdone = c;
            tick();
        end
        chk_eq("b_done_cycle", bdone, 32'd101);
        chk_eq("b_slave_rx_data", {20'b0, sb_rx_data}, 32'h0000_05A3);
        chk_eq("b_slave_rx_valid", {31'b0, sb_rx_valid}, 32'd1);
        chk_eq("b_sclk_idle_after", {31'b0, sclk_b}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
